// File: rtl/note_duration_timer.sv
// Note duration timer: converts a duration code into a counted number of
// timebase ticks, sounding the note for all but a short trailing gap.
module note_duration_timer #(
  parameter int BASE_TICKS = 100,
  parameter int GAP_TICKS  = 2,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       dur_valid,
  input  logic [2:0] dur_code,
  input  logic       dotted,
  input  logic       pause,
  input  logic       abort,
  output logic       dur_ready,
  output logic       note_on,
  output logic       next_note,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_e;

  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_GAP   = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] T_B     = CNT_W'(BASE_TICKS);
  localparam logic [CNT_W-1:0] T_B_2   = CNT_W'(BASE_TICKS / 2);
  localparam logic [CNT_W-1:0] T_B_3   = CNT_W'(BASE_TICKS / 3);
  localparam logic [CNT_W-1:0] T_B_4   = CNT_W'(BASE_TICKS / 4);
  localparam logic [CNT_W-1:0] T_B_6   = CNT_W'(BASE_TICKS / 6);
  localparam logic [CNT_W-1:0] T_2B    = CNT_W'(BASE_TICKS * 2);
  localparam logic [CNT_W-1:0] T_4B    = CNT_W'(BASE_TICKS * 4);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             note_on_q, next_note_q, busy_q;

  logic [CNT_W-1:0] base_len;
  logic [CNT_W-1:0] new_target;
  logic [CNT_W-1:0] play_len;
  logic [CNT_W-1:0] count_inc;
  logic             count_en;
  logic             accept;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    base_len = '0;
    unique case (dur_code)
      3'd0: base_len = '0;
      3'd1: base_len = T_B;
      3'd2: base_len = T_B_2;
      3'd3: base_len = T_B_3;
      3'd4: base_len = T_B_4;
      3'd5: base_len = T_B_6;
      3'd6: base_len = T_2B;
      3'd7: base_len = T_4B;
      default: base_len = '0;
    endcase
    new_target = dotted ? base_len + (base_len >> 1) : base_len;
  end

  // Notes no longer than the gap play their full length with no gap at all.
  assign play_len  = (target_q > T_GAP) ? target_q - T_GAP : target_q;
  assign count_inc = count_q + T_ONE;
  assign count_en  = tick && !pause;
  assign dur_ready = clr_n && (state_q == IDLE) && !abort;
  assign accept    = dur_valid && dur_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          target_d = new_target;
          count_d  = '0;
          state_d  = (new_target == '0) ? DONE : PLAY;
        end
        PLAY: if (count_en) begin
          count_d = count_inc;
          if (count_inc == play_len)
            state_d = (play_len == target_q) ? DONE : GAP;
        end
        GAP: if (count_en) begin
          count_d = count_inc;
          if (count_inc == target_q) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      target_q    <= '0;
      note_on_q   <= 1'b0;
      next_note_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      note_on_q   <= (state_d == PLAY);
      next_note_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign note_on   = note_on_q;
  assign next_note = next_note_q;
  assign busy      = busy_q;

endmodule

// File: doc/note_duration_timer.md
NOTE_DURATION_TIMER -- requirements
Module: note_duration_timer

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 100, meaning tick count of a quarter note.
REQ-002 SHALL have parameter GAP_TICKS, default 2, meaning silent articulation gap taken from the end of each note.
REQ-003 SHALL have parameter CNT_W, default 10, meaning counter/target width; it SHALL hold 6*BASE_TICKS.
REQ-004 SHALL have ports, in this order:
  clk  in  1  rising-edge clock
  clr_n  in  1  asynchronous, active-low reset
  tick  in  1  one-cycle timebase enable pulse
  dur_valid  in  1  duration request valid
  dur_code  in  3  duration code (see REQ-007)
  dotted  in  1  dotted-note modifier, sampled with dur_code
  pause  in  1  level; freezes note timing
  abort  in  1  synchronous cancel of the current note
  dur_ready  out  1  request may be accepted this cycle
  note_on  out  1  note sounding (gates tone generator)
  next_note  out  1  one-cycle pulse: note complete, fetch next
  busy  out  1  note in progress

Function
REQ-005 SHALL implement states IDLE, PLAY, GAP, DONE.
REQ-006 dur_ready SHALL equal (state==IDLE) AND NOT abort; a request is accepted on a rising edge where dur_valid AND dur_ready.
REQ-007 On acceptance, target SHALL be latched: code 0 = 0; 1 = B; 2 = B/2; 3 = B/3; 4 = B/4; 5 = B/6; 6 = 2B; 7 = 4B (B = BASE_TICKS, truncating division).
REQ-008 If dotted=1, target SHALL be base + (base >> 1), computed in CNT_W bits. Dotted with code 0 SHALL still give 0.
REQ-009 On acceptance, count SHALL clear to 0. The next state SHALL be DONE if target==0, otherwise PLAY.
REQ-010 A tick in the acceptance cycle SHALL NOT be counted.
REQ-011 count SHALL increment only on tick AND NOT pause while in PLAY or GAP; otherwise it holds.
REQ-012 Play length SHALL be P = target-GAP_TICKS when target > GAP_TICKS, else P = target with no GAP state.
REQ-013 The PLAY-to-GAP (or PLAY-to-DONE when there is no gap) transition SHALL occur on the counted tick that makes count equal P.
REQ-014 GAP SHALL go to DONE on the counted tick that makes count equal target.
REQ-015 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-016 Total note time SHALL be exactly target counted ticks.
REQ-017 Outputs SHALL be decoded from state only:
  note_on=1 only in PLAY
  next_note=1 only in DONE
  busy=1 in PLAY, GAP and DONE
REQ-018 next_note SHALL rise in the cycle after the edge that consumes the final counted tick.
REQ-019 pause SHALL NOT change state or outputs. Pause asserted in IDLE SHALL have no effect.
REQ-020 abort SHALL force IDLE on the next edge from any state and clear count. Abort from PLAY, GAP or DONE SHALL produce no next_note pulse in the following cycles.
REQ-021 abort SHALL have priority over tick, pause and dur_valid.
REQ-022 In IDLE, tick SHALL be ignored. dur_code and dotted SHALL be don't-care when not accepted.

Reset
REQ-023 While clr_n=0, the block SHALL asynchronously enter IDLE with count=0 and target=0.
REQ-024 While clr_n=0, outputs SHALL be note_on=0, next_note=0, busy=0 and dur_ready=0.
REQ-025 After clr_n deasserts, dur_ready SHALL be 1 from the first cycle if abort=0.
REQ-026 Reset asserted mid-note SHALL discard the note and produce no next_note pulse.

Verification
REQ-027 Reset mid-PLAY (code 1, count 40): pull clr_n low between edges -> note_on, busy, next_note go 0 immediately; after release, dur_ready=1 and no next_note.
REQ-028 Quarter note (code 1, dotted 0, tick every cycle, defaults) -> note_on high 98 cycles, low 2 cycles, next_note high 1 cycle, then dur_ready=1.
REQ-029 Dotted eighth (code 2, dotted 1) -> target 75, note_on 73 ticks; sixth (code 5) -> target 16; dotted sixth -> target 24.
REQ-030 Pause held 10 cycles mid-PLAY, tick every cycle -> note_on stays 1 throughout; next_note is 10 cycles later than REQ-028.
REQ-031 abort during GAP -> IDLE next cycle, no next_note; code 0 accepted -> next_note pulses in the cycle after acceptance with note_on never high.
REQ-032 BASE_TICKS=4, GAP_TICKS=2, code 5 (target 0) and code 4 (target 1, at or below the gap) -> no GAP state; note_on lasts 1 tick for code 4.
